// File: rtl/reset_seq_ctrl.sv
// Staged reset-release sequencer: holds all domain resets, then releases them in index order,
// waiting for each domain's ready. Define RESET_SEQ_TIMEOUT_EN to add the WAIT timeout/auto-retry.
module reset_seq_ctrl #(
    parameter int  NUM_STAGES     = 4,
    parameter int  ASSERT_CYCLES  = 16,
    parameter int  GAP_CYCLES     = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int SW             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_rst_req,
    input  logic [NUM_STAGES-1:0] i_ready,
    output logic [NUM_STAGES-1:0] o_rstn,
    output logic [SW-1:0]         o_stage,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [SW-1:0]         o_timeout_stage
);

    localparam int AG_MAX = (ASSERT_CYCLES > GAP_CYCLES) ? ASSERT_CYCLES : GAP_CYCLES;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > AG_MAX) ? TIMEOUT_CYCLES : AG_MAX;
`else
    localparam int CNT_MAX = AG_MAX;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] ASSERT_LAST = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [SW-1:0] LAST_STAGE  = SW'(NUM_STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
`endif

    if (NUM_STAGES < 1 || ASSERT_CYCLES < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("reset_seq_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [SW-1:0]         stage_reg;
    logic [NUM_STAGES-1:0] rstn_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [NUM_STAGES-1:0] ready_meta_reg;
    logic [NUM_STAGES-1:0] ready_sync_reg;
    logic [NUM_STAGES-1:0] release_mask;
    logic                  ready_sel;

    // Ready bits come from other clock domains; only the second flop is ever looked at.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ready_meta_reg <= '0;
            ready_sync_reg <= '0;
        end else begin
            ready_meta_reg <= i_ready;
            ready_sync_reg <= ready_meta_reg;
        end
    end

    // One-hot mask of the stage that follows the current one.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
        if (gi == 0) begin : g_first
            assign release_mask[gi] = 1'b0;
        end else begin : g_next
            assign release_mask[gi] = (stage_reg == SW'(gi - 1));
        end
    end

    assign ready_sel = ready_sync_reg[stage_reg];

`ifdef RESET_SEQ_TIMEOUT_EN
    logic          timeout_reg;
    logic [SW-1:0] timeout_stage_reg;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= ST_ASSERT;
            cnt_reg   <= '0;
            stage_reg <= '0;
            rstn_reg  <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_reg       <= 1'b0;
            timeout_stage_reg <= '0;
`endif
        end else if (i_rst_req) begin
            // Request beats any ready or timeout seen this cycle and keeps the hold counter at zero.
            state_reg <= ST_ASSERT;
            cnt_reg   <= '0;
            stage_reg <= '0;
            rstn_reg  <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    if (cnt_reg == ASSERT_LAST) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= '0;
                        stage_reg <= '0;
                        rstn_reg  <= NUM_STAGES'(1);
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (ready_sel) begin
                        cnt_reg <= '0;
                        if (stage_reg == LAST_STAGE) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            rstn_reg  <= rstn_reg | release_mask;
                            stage_reg <= stage_reg + SW'(1);
                        end else begin
                            state_reg <= ST_GAP;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (cnt_reg == TO_LAST) begin
                        timeout_reg       <= 1'b1;
                        timeout_stage_reg <= stage_reg;
                        state_reg         <= ST_ASSERT;
                        cnt_reg           <= '0;
                        stage_reg         <= '0;
                        rstn_reg          <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= '0;
                        rstn_reg  <= rstn_reg | release_mask;
                        stage_reg <= stage_reg + SW'(1);
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_ASSERT;
                    cnt_reg   <= '0;
                    stage_reg <= '0;
                    rstn_reg  <= '0;
                    busy_reg  <= 1'b1;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rstn  = rstn_reg;
    assign o_stage = stage_reg;
    assign o_busy  = busy_reg;
    assign o_done  = done_reg;

`ifdef RESET_SEQ_TIMEOUT_EN
    assign o_timeout       = timeout_reg;
    assign o_timeout_stage = timeout_stage_reg;
`else
    assign o_timeout       = 1'b0;
    assign o_timeout_stage = '0;
`endif

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: expected output snapshots are queued with the cycle they are due
// and compared by a negedge monitor.
module tb_reset_seq_ctrl;

    logic       i_clk     = 1'b0;
    logic       i_rstn    = 1'b1;
    logic       i_rst_req = 1'b0;
    logic [3:0] i_ready   = 4'hF;
    logic [3:0] o_rstn;
    logic [1:0] o_stage;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout;
    logic [1:0] o_timeout_stage;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    string      tag_q[$];
    int         cyc_q[$];
    logic [10:0] exp_q[$];

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [1:0] TS_AFTER = 2'd2;
`else
    localparam logic [1:0] TS_AFTER = 2'd0;
`endif

    reset_seq_ctrl #(
        .NUM_STAGES    (4),
        .ASSERT_CYCLES (16),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_rst_req      (i_rst_req),
        .i_ready        (i_ready),
        .o_rstn         (o_rstn),
        .o_stage        (o_stage),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_timeout      (o_timeout),
        .o_timeout_stage(o_timeout_stage)
    );

    always #5 i_clk = ~i_clk;

    // Edge count since the last i_rstn release: after edge n, cyc == n.
    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic [10:0] mk(logic [3:0] r, logic [1:0] s, logic b, logic d, logic t, logic [1:0] ts);
        return {r, s, b, d, t, ts};
    endfunction

    task automatic expect_at(string tag, int c, logic [10:0] e);
        tag_q.push_back(tag);
        cyc_q.push_back(c);
        exp_q.push_back(e);
    endtask

    task automatic check_front();
        string       t;
        int          c;
        logic [10:0] e;
        logic [10:0] o;
        t = tag_q.pop_front();
        c = cyc_q.pop_front();
        e = exp_q.pop_front();
        o = {o_rstn, o_stage, o_busy, o_done, o_timeout, o_timeout_stage};
        tests++;
        assert (o === e) begin
            $display("[TB] %s cyc=%0d ok rstn=%b stage=%0d busy=%b done=%b to=%b ts=%0d",
                     t, cyc, o[10:7], o[6:5], o[4], o[3], o[2], o[1:0]);
        end else begin
            fails++;
            $error("FAIL %s cyc=%0d due=%0d got rstn=%b stage=%0d busy=%b done=%b to=%b ts=%0d expected rstn=%b stage=%0d busy=%b done=%b to=%b ts=%0d",
                   t, cyc, c, o[10:7], o[6:5], o[4], o[3], o[2], o[1:0],
                   e[10:7], e[6:5], e[4], e[3], e[2], e[1:0]);
        end
    endtask

    always @(negedge i_clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] >= 0 && cyc_q[0] <= cyc) check_front();
    end

    task automatic drain(int budget);
        int n;
        n = 0;
        while (cyc_q.size() > 0 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        while (cyc_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s never reached due cycle %0d (now %0d)", tag_q[0], cyc_q[0], cyc);
            void'(tag_q.pop_front());
            void'(cyc_q.pop_front());
            void'(exp_q.pop_front());
        end
    endtask

    task automatic wait_cyc(int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge i_clk);
            guard++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, simulation hung");
        $fatal(1, "watchdog");
    end

    initial begin
        int q;
        #1 i_rstn = 1'b0;
        i_ready = 4'hF;
        repeat (2) @(negedge i_clk);
        expect_at("reset_hold", 0, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        drain(5);

        // Power-up with every ready already high.
        expect_at("pwr_r0_low", 15, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("pwr_r0",     16, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("pwr_r1_low", 20, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("pwr_r1",     21, mk(4'b0011, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("pwr_r2",     26, mk(4'b0111, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("pwr_r3",     31, mk(4'b1111, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("pwr_done",   32, mk(4'b1111, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0));
        i_rstn = 1'b1;
        drain(60);

        // Late ready on stage 1.
        q = cyc + 1;
        expect_at("late_req",     q,      mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("late_r0_low",  q + 15, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("late_r0",      q + 16, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("late_r1",      q + 21, mk(4'b0011, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("late_hold",    q + 76, mk(4'b0011, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("late_r2",      q + 77, mk(4'b0111, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("late_r3",      q + 82, mk(4'b1111, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("late_done",    q + 83, mk(4'b1111, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0));
        i_rst_req = 1'b1;
        i_ready   = 4'b1101;
        @(negedge i_clk);
        i_rst_req = 1'b0;
        wait_cyc(q + 70);
        i_ready = 4'hF;
        drain(100);

        // Ten-cycle request while waiting on stage 2.
        q = cyc + 1;
        expect_at("mid_req0",     q,      mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("mid_wait2",    q + 26, mk(4'b0111, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("mid_pre",      q + 30, mk(4'b0111, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("mid_first",    q + 31, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("mid_last",     q + 40, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("mid_r0_low",   q + 55, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("mid_r0",       q + 56, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("mid_done",     q + 72, mk(4'b1111, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0));
        i_rst_req = 1'b1;
        i_ready   = 4'b1011;
        @(negedge i_clk);
        i_rst_req = 1'b0;
        wait_cyc(q + 30);
        i_rst_req = 1'b1;
        wait_cyc(q + 40);
        i_rst_req = 1'b0;
        i_ready   = 4'hF;
        drain(100);

        // Request in DONE coinciding with a ready glitch.
        q = cyc + 1;
        expect_at("glitch_req",  q,      mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("glitch_next", q + 1,  mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("glitch_r0",   q + 16, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("glitch_done", q + 32, mk(4'b1111, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0));
        i_rst_req = 1'b1;
        i_ready   = 4'b0111;
        @(negedge i_clk);
        i_rst_req = 1'b0;
        i_ready   = 4'hF;
        drain(60);

        // Stage 2 ready withheld.
        q = cyc + 1;
        expect_at("stall_wait2", q + 26, mk(4'b0111, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
`ifdef RESET_SEQ_TIMEOUT_EN
        expect_at("to_before",   q + 89,  mk(4'b0111, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("to_fire",     q + 90,  mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2));
        expect_at("to_retry_r0", q + 106, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2));
        expect_at("to_clear",    q + 111, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2));
        expect_at("to_done",     q + 143, mk(4'b1111, 2'd3, 1'b0, 1'b1, 1'b0, 2'd2));
        i_rst_req = 1'b1;
        i_ready   = 4'b1011;
        @(negedge i_clk);
        i_rst_req = 1'b0;
        wait_cyc(q + 110);
        i_rst_req = 1'b1;
        wait_cyc(q + 111);
        i_rst_req = 1'b0;
        i_ready   = 4'hF;
        drain(200);
`else
        expect_at("stall_long",  q + 200, mk(4'b0111, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("stall_r3",    q + 207, mk(4'b1111, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("stall_done",  q + 208, mk(4'b1111, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0));
        i_rst_req = 1'b1;
        i_ready   = 4'b1011;
        @(negedge i_clk);
        i_rst_req = 1'b0;
        wait_cyc(q + 200);
        i_ready = 4'hF;
        drain(250);
`endif

        // Asynchronous reset in the middle of a GAP.
        q = cyc + 1;
        expect_at("gap_in", q + 17, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, TS_AFTER));
        i_rst_req = 1'b1;
        @(negedge i_clk);
        i_rst_req = 1'b0;
        wait_cyc(q + 18);
        #2 i_rstn = 1'b0;
        #1;
        expect_at("async_mid_gap", -1, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        check_front();
        repeat (3) @(negedge i_clk);
        expect_at("rerun_r0_low", 15, mk(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("rerun_r0",     16, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        expect_at("rerun_done",   32, mk(4'b1111, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0));
        i_rstn = 1'b1;
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
